parking_duration_tracker: RTL and testbench

Multi-slot parking-duration engine. It keeps a free-running parking clock and records an entry timestamp per slot. On exit it computes the elapsed time as a modulo-2^TIME_W difference and reports it with a one-cycle registered result. It sits between the gate/sensor controllers and the billing logic, and generalises the single-pair time subtraction to SLOTS independent channels with occupancy tracking and error reporting.

---
 rtl/parking_pkg.sv | 12 +
 rtl/parking_duration_tracker_time_sub.sv | 13 +
 rtl/parking_duration_tracker.sv | 145 ++++++++++++++
 tb/tb_parking_duration_tracker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking duration tracker: error codes reported
// alongside rejected entry/exit requests.
package parking_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OCCUPIED = 2'b01,
    ERR_FREE     = 2'b10,
    ERR_RANGE    = 2'b11
  } err_code_e;

endpackage

// File: rtl/parking_duration_tracker_time_sub.sv
// Combinational modulo-2^WIDTH subtractor; the borrow out is discarded so a
// wrapped time base still yields the correct elapsed count.
module time_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff
);

  assign o_diff = i_a - i_b;

endmodule

// File: rtl/parking_duration_tracker.sv
// Multi-slot parking duration engine: free-running parking clock, per-slot
// entry timestamps, registered duration results and error pulses.
module parking_duration_tracker
  import parking_pkg::*;
#(
  parameter int TIME_W = 8,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              entry_valid,
  input  logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_valid,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic [TIME_W-1:0] now,
  output logic [SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]   free_count,
  output logic              full,
  output logic              empty,
  output logic              dur_valid,
  output logic [SLOT_W-1:0] dur_slot,
  output logic [TIME_W-1:0] duration,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  typedef logic [TIME_W-1:0] time_t;

  localparam int SLOTS_P2 = 1 << SLOT_W;

  time_t             r_now;
  time_t             r_ts [SLOTS];
  logic [SLOTS-1:0]  r_occupied;
  logic [SLOT_W:0]   r_free_count;
  logic              r_full;
  logic              r_empty;
  logic              r_dur_valid;
  logic [SLOT_W-1:0] r_dur_slot;
  time_t             r_duration;
  logic              r_err_valid;
  err_code_e         r_err_code;

  logic [SLOTS_P2-1:0] w_occ_pad;
  logic                w_exit_range;
  logic                w_entry_range;
  logic                w_exit_legal;
  logic                w_entry_legal;
  err_code_e           w_err_code;
  time_t               w_ts_sel;
  time_t               w_diff;
  logic [SLOTS-1:0]    w_occ_next;
  logic [SLOT_W:0]     w_free_next;

  // Padding to a power of two keeps occupancy lookups in bounds for any index.
  assign w_occ_pad     = SLOTS_P2'(r_occupied);
  assign w_exit_range  = {1'b0, exit_slot}  >= (SLOT_W+1)'(SLOTS);
  assign w_entry_range = {1'b0, entry_slot} >= (SLOT_W+1)'(SLOTS);
  assign w_exit_legal  = exit_valid && !w_exit_range && w_occ_pad[exit_slot];
  // A same-slot exit frees the slot before the entry is considered.
  assign w_entry_legal = entry_valid && !w_entry_range &&
                         (!w_occ_pad[entry_slot] ||
                          (w_exit_legal && exit_slot == entry_slot));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_ts_sel = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (exit_slot == SLOT_W'(i)) w_ts_sel = r_ts[i];
    end
  end

  time_sub #(.WIDTH(TIME_W)) u_time_sub (
    .i_a    (r_now),
    .i_b    (w_ts_sel),
    .o_diff (w_diff)
  );

  always_comb begin
    w_err_code = ERR_NONE;
    if (exit_valid && !w_exit_legal)
      w_err_code = w_exit_range ? ERR_RANGE : ERR_FREE;
    else if (entry_valid && !w_entry_legal)
      w_err_code = w_entry_range ? ERR_RANGE : ERR_OCCUPIED;
  end

  always_comb begin
    w_occ_next  = r_occupied;
    w_free_next = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_exit_legal  && exit_slot  == SLOT_W'(i)) w_occ_next[i] = 1'b0;
      if (w_entry_legal && entry_slot == SLOT_W'(i)) w_occ_next[i] = 1'b1;
    end
    for (int i = 0; i < SLOTS; i++) begin
      w_free_next = w_free_next + (SLOT_W+1)'(!w_occ_next[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now        <= '0;
      r_occupied   <= '0;
      r_free_count <= (SLOT_W+1)'(SLOTS);
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_dur_valid  <= 1'b0;
      r_dur_slot   <= '0;
      r_duration   <= '0;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
      // NOTE: timestamps live in flops rather than RAM precisely so reset can clear them.
      for (int i = 0; i < SLOTS; i++) r_ts[i] <= '0;
    end else begin
      if (tick) r_now <= r_now + 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
        if (w_entry_legal && entry_slot == SLOT_W'(i)) r_ts[i] <= r_now;
      end
      r_occupied   <= w_occ_next;
      r_free_count <= w_free_next;
      r_full       <= &w_occ_next;
      r_empty      <= ~|w_occ_next;
      r_dur_valid  <= w_exit_legal;
      if (w_exit_legal) begin
        r_dur_slot <= exit_slot;
        r_duration <= w_diff;
      end
      r_err_valid  <= (w_err_code != ERR_NONE);
      r_err_code   <= w_err_code;
    end
  end

  assign now        = r_now;
  assign occupied   = r_occupied;
  assign free_count = r_free_count;
  assign full       = r_full;
  assign empty      = r_empty;
  assign dur_valid  = r_dur_valid;
  assign dur_slot   = r_dur_slot;
  assign duration   = r_duration;
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_parking_duration_tracker.sv
// Directed bench for parking_duration_tracker: a default 4-slot instance and a
// 3-slot instance sharing stimulus for the out-of-range index case.
module tb_parking_duration_tracker;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       entry_valid;
  logic [1:0] entry_slot;
  logic       exit_valid;
  logic [1:0] exit_slot;

  logic [7:0] now;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic       full, empty, dur_valid, err_valid;
  logic [1:0] dur_slot, err_code;
  logic [7:0] duration;

  logic [7:0] d3_now;
  logic [2:0] d3_occupied;
  logic [2:0] d3_free_count;
  logic       d3_full, d3_empty, d3_dur_valid, d3_err_valid;
  logic [1:0] d3_dur_slot, d3_err_code;
  logic [7:0] d3_duration;

  int n_pass  = 0;
  int n_total = 0;

  parking_duration_tracker dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .now(now), .occupied(occupied), .free_count(free_count),
    .full(full), .empty(empty), .dur_valid(dur_valid),
    .dur_slot(dur_slot), .duration(duration),
    .err_valid(err_valid), .err_code(err_code)
  );

  parking_duration_tracker #(.TIME_W(8), .SLOTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .now(d3_now), .occupied(d3_occupied), .free_count(d3_free_count),
    .full(d3_full), .empty(d3_empty), .dur_valid(d3_dur_valid),
    .dur_slot(d3_dur_slot), .duration(d3_duration),
    .err_valid(d3_err_valid), .err_code(d3_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cycle(input logic tk, input logic ev, input logic [1:0] es,
                       input logic xv, input logic [1:0] xs);
    tick = tk; entry_valid = ev; entry_slot = es; exit_valid = xv; exit_slot = xs;
    @(posedge clk);
    #1;
    tick = 0; entry_valid = 0; exit_valid = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 0; tick = 0; entry_valid = 0; entry_slot = 0; exit_valid = 0; exit_slot = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (now !== 8'd0) $display("FAIL reset_now got %0d exp 0", now); else n_pass++;
    n_total++; if (occupied !== 4'b0000) $display("FAIL reset_occ got %b exp 0000", occupied); else n_pass++;
    n_total++; if (free_count !== 3'd4) $display("FAIL reset_free got %0d exp 4", free_count); else n_pass++;
    n_total++; if ({full, empty} !== 2'b01) $display("FAIL reset_full_empty got %b exp 01", {full, empty}); else n_pass++;
    n_total++; if ({dur_valid, err_valid} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {dur_valid, err_valid}); else n_pass++;
    n_total++; if ({dur_slot, duration, err_code} !== 12'd0) $display("FAIL reset_result got %h exp 0", {dur_slot, duration, err_code}); else n_pass++;
  endtask

  task automatic test_basic();
    ticks(5);
    n_total++; if (now !== 8'd5) $display("FAIL basic_now got %0d exp 5", now); else n_pass++;
    cycle(0, 1, 2, 0, 0);
    n_total++; if (occupied !== 4'b0100) $display("FAIL basic_occ got %b exp 0100", occupied); else n_pass++;
    n_total++; if ({free_count, empty} !== {3'd3, 1'b0}) $display("FAIL basic_free got %b exp 0110", {free_count, empty}); else n_pass++;
    ticks(7);
    cycle(0, 0, 0, 1, 2);
    n_total++; if ({dur_valid, dur_slot, duration} !== {1'b1, 2'd2, 8'd7}) $display("FAIL basic_dur got v%b s%0d d%0d exp v1 s2 d7", dur_valid, dur_slot, duration); else n_pass++;
    n_total++; if ({occupied, empty} !== 5'b00001) $display("FAIL basic_exit_occ got %b exp 00001", {occupied, empty}); else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_total++; if (dur_valid !== 1'b0) $display("FAIL basic_pulse_width got %b exp 0", dur_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    ticks(238);
    n_total++; if (now !== 8'd250) $display("FAIL wrap_start got %0d exp 250", now); else n_pass++;
    cycle(0, 1, 0, 0, 0);
    ticks(10);
    n_total++; if (now !== 8'd4) $display("FAIL wrap_now got %0d exp 4", now); else n_pass++;
    cycle(0, 0, 0, 1, 0);
    n_total++; if ({dur_valid, duration} !== {1'b1, 8'd10}) $display("FAIL wrap_dur got v%b d%0d exp v1 d10", dur_valid, duration); else n_pass++;
  endtask

  task automatic test_full();
    for (int s = 0; s < 4; s++) cycle(0, 1, 2'(s), 0, 0);
    n_total++; if ({full, empty, free_count} !== {1'b1, 1'b0, 3'd0}) $display("FAIL full_flags got %b exp 10000", {full, empty, free_count}); else n_pass++;
    cycle(0, 1, 1, 0, 0);
    n_total++; if ({err_valid, err_code} !== 3'b101) $display("FAIL full_err got %b exp 101", {err_valid, err_code}); else n_pass++;
    n_total++; if ({occupied, full} !== 5'b11111) $display("FAIL full_unchanged got %b exp 11111", {occupied, full}); else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_total++; if (err_valid !== 1'b0) $display("FAIL full_err_width got %b exp 0", err_valid); else n_pass++;
  endtask

  task automatic test_exit_free();
    cycle(0, 0, 0, 1, 3);
    n_total++; if ({dur_valid, occupied} !== 5'b10111) $display("FAIL exit3_legal got %b exp 10111", {dur_valid, occupied}); else n_pass++;
    cycle(0, 0, 0, 1, 3);
    n_total++; if ({err_valid, err_code, dur_valid} !== 4'b1100) $display("FAIL exit_free_err got %b exp 1100", {err_valid, err_code, dur_valid}); else n_pass++;
    cycle(0, 1, 0, 1, 3);
    n_total++; if ({err_valid, err_code, occupied} !== 7'b1100111) $display("FAIL both_illegal got %b exp 1100111", {err_valid, err_code, occupied}); else n_pass++;
  endtask

  task automatic test_same_cycle();
    apply_reset();
    ticks(4);
    cycle(0, 1, 0, 0, 0);
    ticks(5);
    n_total++; if (now !== 8'd9) $display("FAIL same_pre_now got %0d exp 9", now); else n_pass++;
    cycle(1, 1, 0, 1, 0);
    n_total++; if ({dur_valid, dur_slot, duration} !== {1'b1, 2'd0, 8'd5}) $display("FAIL same_dur got v%b s%0d d%0d exp v1 s0 d5", dur_valid, dur_slot, duration); else n_pass++;
    n_total++; if ({occupied, now, err_valid} !== {4'b0001, 8'd10, 1'b0}) $display("FAIL same_state got %b/%0d/%b exp 0001/10/0", occupied, now, err_valid); else n_pass++;
    cycle(0, 1, 1, 1, 1);
    n_total++; if ({err_valid, err_code, dur_valid, occupied} !== 8'b11000011) $display("FAIL same_free got %b exp 11000011", {err_valid, err_code, dur_valid, occupied}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    ticks(3);
    cycle(0, 0, 0, 1, 0);
    n_total++; if ({dur_valid, dur_slot, duration} !== {1'b1, 2'd0, 8'd4}) $display("FAIL b2b_first got v%b s%0d d%0d exp v1 s0 d4", dur_valid, dur_slot, duration); else n_pass++;
    cycle(0, 0, 0, 1, 1);
    n_total++; if ({dur_valid, dur_slot, duration} !== {1'b1, 2'd1, 8'd3}) $display("FAIL b2b_second got v%b s%0d d%0d exp v1 s1 d3", dur_valid, dur_slot, duration); else n_pass++;
    n_total++; if ({occupied, empty} !== 5'b00001) $display("FAIL b2b_empty got %b exp 00001", {occupied, empty}); else n_pass++;
    cycle(0, 1, 2, 1, 3);
    n_total++; if ({occupied, err_valid, err_code} !== 7'b0100110) $display("FAIL diff_slots got %b exp 0100110", {occupied, err_valid, err_code}); else n_pass++;
  endtask

  task automatic test_range();
    apply_reset();
    cycle(0, 1, 3, 0, 0);
    n_total++; if ({d3_err_valid, d3_err_code} !== 3'b111) $display("FAIL range_err got %b exp 111", {d3_err_valid, d3_err_code}); else n_pass++;
    n_total++; if ({d3_occupied, d3_free_count} !== 6'b000011) $display("FAIL range_state got %b exp 000011", {d3_occupied, d3_free_count}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ticks(2);
    for (int s = 0; s < 3; s++) cycle(0, 1, 2'(s), 0, 0);
    n_total++; if (occupied !== 4'b0111) $display("FAIL mid_pre_occ got %b exp 0111", occupied); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++; if ({occupied, free_count, empty, full, now} !== {4'b0000, 3'd4, 1'b1, 1'b0, 8'd0}) $display("FAIL mid_async got %b/%0d/%b%b/%0d exp 0000/4/10/0", occupied, free_count, empty, full, now); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    cycle(0, 0, 0, 1, 0);
    n_total++; if ({err_valid, err_code, dur_valid} !== 4'b1100) $display("FAIL mid_exit_err got %b exp 1100", {err_valid, err_code, dur_valid}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_exit_free();
    test_same_cycle();
    test_back_to_back();
    test_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
